// File: rtl/instr_sequencer.sv
// instr_sequencer: fetch/decode/exec/mem/writeback sequencer with PC, instruction register and retire counter.
module instr_sequencer #(
   parameter int ADDR_W = 8,
   parameter logic [ADDR_W-1:0] PC_RESET = '0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic              imem_ack,
   input  logic [23:0]       imem_data,
   output logic [23:0]       code,
   input  logic              branch_taken,
   input  logic [ADDR_W-1:0] branch_target,
   input  logic              mem_busy,
   output logic              wr_en,
   output logic              halted,
   output logic [15:0]       retired
);
   typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;
   state_t state;
   logic [ADDR_W-1:0] pc;
   logic take;
   assign imem_addr = pc;
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         pc       <= PC_RESET;
         code     <= '0;
         retired  <= '0;
         imem_req <= 1'b0;
         wr_en    <= 1'b0;
         halted   <= 1'b0;
         take     <= 1'b0;
      end else begin
         case (state)
            IDLE, HALT: if (start) begin
               state    <= FETCH;
               imem_req <= 1'b1;
               halted   <= 1'b0;
            end
            FETCH: if (imem_ack) begin
               code     <= imem_data;
               imem_req <= 1'b0;
               state    <= DECODE;
            end
            DECODE: begin
               state  <= (code == 24'hFFFFFF) ? HALT : EXEC;
               halted <= (code == 24'hFFFFFF);
            end
            EXEC: begin
               state <= (code[23:22] == 2'b10) ? MEM : WB;
               wr_en <= (code[23:22] == 2'b00) || (code[23:22] == 2'b01);
               take  <= (code[23:22] == 2'b11) && branch_taken;
            end
            MEM: if (!mem_busy) begin
               state <= WB;
               wr_en <= 1'b1;
            end
            WB: begin
               state    <= FETCH;
               imem_req <= 1'b1;
               wr_en    <= 1'b0;
               pc       <= take ? branch_target : pc + 1'b1;
               retired  <= (retired == 16'hFFFF) ? retired : retired + 16'd1;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_instr_sequencer.sv
// tb_instr_sequencer: directed checks of the instruction sequencer against hand-computed values.
module tb_instr_sequencer;
   logic clk = 0, reset = 1, start = 0, imem_ack, branch_taken = 0, mem_busy = 0, ack_en = 1;
   logic imem_req, wr_en, halted;
   logic [7:0] imem_addr, branch_target = 8'h00;
   logic [23:0] imem_data, code;
   logic [15:0] retired;
   logic [23:0] mem [256];
   int n_cmp = 0, n_bad = 0, wr_cnt = 0;

   instr_sequencer dut (
      .clk(clk), .reset(reset), .start(start), .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_ack(imem_ack), .imem_data(imem_data), .code(code), .branch_taken(branch_taken),
      .branch_target(branch_target), .mem_busy(mem_busy), .wr_en(wr_en), .halted(halted),
      .retired(retired)
   );

   always #5 clk = ~clk;
   assign imem_ack  = imem_req & ack_en;
   assign imem_data = mem[imem_addr];
   always @(negedge clk) if (wr_en) wr_cnt++;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 24'h0;
      mem[0] = 24'h000130; mem[1] = 24'h800001; mem[2] = 24'hC00000;
      mem[8'h40] = 24'hC00000; mem[8'h41] = 24'hFFFFFF; mem[8'hFF] = 24'h000001;
      tick(2);
      reset = 0;
      chk("rst_req", imem_req, 0); chk("rst_wr", wr_en, 0); chk("rst_halt", halted, 0);
      chk("rst_ret", retired, 0); chk("rst_code", code, 0); chk("rst_pc", imem_addr, 0);
      start = 1; tick(); start = 0;
      chk("fetch_req", imem_req, 1); chk("fetch_addr", imem_addr, 0);
      tick();
      chk("dec_code", code, 24'h000130); chk("dec_req", imem_req, 0);
      tick(2);
      chk("alu_wr", wr_en, 1);
      tick();
      chk("alu_pc", imem_addr, 1); chk("alu_ret", retired, 1); chk("alu_wr_off", wr_en, 0);
      chk("alu_wr_cnt", wr_cnt, 1); chk("alu_req", imem_req, 1);
      mem_busy = 1; wr_cnt = 0;
      tick(3);
      chk("mem_code", code, 24'h800001);
      for (int i = 0; i < 3; i++) begin tick(); chk("mem_wait_wr", wr_en, 0); end
      mem_busy = 0; tick();
      chk("mem_wr", wr_en, 1);
      tick();
      chk("mem_pc", imem_addr, 2); chk("mem_ret", retired, 2); chk("mem_wr_cnt", wr_cnt, 1);
      branch_taken = 1; branch_target = 8'h40; wr_cnt = 0;
      tick(3); branch_taken = 0; tick();
      chk("bt_pc", imem_addr, 8'h40); chk("bt_wr_cnt", wr_cnt, 0); chk("bt_ret", retired, 3);
      tick(4);
      chk("bn_pc", imem_addr, 8'h41); chk("bn_wr_cnt", wr_cnt, 0); chk("bn_ret", retired, 4);
      tick(3);
      chk("halt_code", code, 24'hFFFFFF);
      for (int i = 0; i < 10; i++) begin
         chk("halt_flag", halted, 1); chk("halt_req", imem_req, 0); tick();
      end
      chk("halt_ret", retired, 4); chk("halt_pc", imem_addr, 8'h41);
      mem[8'h41] = 24'hC00000; branch_taken = 1; branch_target = 8'hFF;
      start = 1; tick(); start = 0;
      chk("resume_req", imem_req, 1); chk("resume_pc", imem_addr, 8'h41); chk("resume_halt", halted, 0);
      tick(4);
      chk("jmp_pc", imem_addr, 8'hFF);
      branch_taken = 0; wr_cnt = 0;
      tick(4);
      chk("wrap_pc", imem_addr, 8'h00); chk("wrap_ret", retired, 6); chk("wrap_wr_cnt", wr_cnt, 1);
      reset = 1; tick(); reset = 0;
      mem[0] = 24'h800001; mem_busy = 1; wr_cnt = 0;
      start = 1; tick(); start = 0; tick(4);
      chk("midmem_code", code, 24'h800001);
      reset = 1; tick(); reset = 0; mem_busy = 0;
      chk("midmem_pc", imem_addr, 0); chk("midmem_code0", code, 0); chk("midmem_req", imem_req, 0);
      chk("midmem_ret", retired, 0);
      tick(3);
      chk("midmem_wr_cnt", wr_cnt, 0); chk("midmem_idle", imem_req, 0);
      mem[0] = 24'h000130; ack_en = 0;
      start = 1; tick(); start = 0; tick(2);
      chk("midfetch_req", imem_req, 1);
      ack_en = 1; reset = 1; tick(); reset = 0;
      chk("midfetch_code", code, 0); chk("midfetch_req0", imem_req, 0);
      tick(3);
      chk("midfetch_idle", imem_req, 0); chk("midfetch_wr_cnt", wr_cnt, 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/instr_sequencer.md
INSTR_SEQUENCER -- requirements
Module: instr_sequencer

Interface
REQ-001 Parameter ADDR_W, default 8, program-counter and instruction-address width.
REQ-002 Parameter PC_RESET, default 0, PC value loaded on reset.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  leaves IDLE or HALT and begins fetching at the current PC.
REQ-006 imem_req  output  1  instruction-memory read request.
REQ-007 imem_addr  output  ADDR_W  instruction address; always equal to PC.
REQ-008 imem_ack  input  1  instruction-memory data valid this cycle.
REQ-009 imem_data  input  24  fetched instruction word.
REQ-010 code  output  24  instruction register; feeds the control unit.
REQ-011 branch_taken  input  1  comparator result for a class-11 instruction.
REQ-012 branch_target  input  ADDR_W  branch destination address.
REQ-013 mem_busy  input  1  data memory is still completing an access.
REQ-014 wr_en  output  1  commit strobe that gates register-bank, flag and data-memory writes.
REQ-015 halted  output  1  high in the HALT state.
REQ-016 retired  output  16  count of completed instructions.

Function
REQ-017 States: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT; one state per cycle unless waiting.
REQ-018 IDLE: hold the PC; start=1 moves to FETCH next cycle.
REQ-019 FETCH: imem_req=1 while waiting; on the imem_ack cycle, code <= imem_data and the FSM moves to DECODE.
REQ-020 imem_req is registered and drops the cycle after ack; there is no FETCH timeout.
REQ-021 DECODE: code == 24'hFFFFFF moves to HALT; otherwise the FSM moves to EXEC.
REQ-022 EXEC, by code[23:22]:
 - 00 (ALU) and 01 (immediate) move to WB.
 - 10 (memory) moves to MEM.
 - 11 (branch) moves to WB.
REQ-023 MEM: stay while mem_busy=1; move to WB in the first cycle mem_busy=0.
REQ-024 wr_en=1 only in the WB cycle, for exactly one cycle per instruction; wr_en is never 1 for a branch.
REQ-025 WB: FSM moves to FETCH; retired increments by 1 and saturates at 16'hFFFF.
REQ-026 PC update at the end of WB:
 - Branch class with branch_taken=1 (sampled in EXEC, held in a register): PC <= branch_target.
 - Otherwise: PC <= PC+1, wrapping 2^ADDR_W-1 -> 0.
REQ-027 HALT: halted=1, no requests, PC and code held; start=1 moves to FETCH at the held PC.
REQ-028 code is stable from DECODE through WB; a change on imem_data outside the ack cycle has no effect.
REQ-029 Latency with zero-wait memories: ALU, immediate and branch instructions take 4 cycles (FETCH, DECODE, EXEC, WB); memory instructions take 5.

Reset
REQ-030 reset=1 at a rising edge forces, from any state:
 - state=IDLE, PC=PC_RESET, code=0, retired=0;
 - imem_req=0, wr_en=0, halted=0.
REQ-031 Reset takes priority over start, imem_ack and every other input in the same cycle.
REQ-032 reset asserted mid-FETCH or mid-MEM abandons the operation; no wr_en is issued and no late ack is captured.

Verification
REQ-033 ALU instruction: reset, then start; imem returns 24'h000130 with ack in the first FETCH cycle -> code=24'h000130 in DECODE, wr_en one cycle 4 cycles later, PC 0->1, retired=1.
REQ-034 Memory wait: instruction 24'h800001 with mem_busy=1 for 3 cycles -> MEM lasts 4 cycles, single wr_en pulse, PC increments.
REQ-035 Branch: instruction 24'hC00000 with branch_taken=1 and branch_target=8'h40 -> no wr_en, next imem_addr=8'h40; repeated with branch_taken=0 -> next imem_addr=PC+1.
REQ-036 Wrap: non-branch instruction retired at PC=8'hFF -> next imem_addr=8'h00.
REQ-037 Halt: fetch 24'hFFFFFF -> halted=1, imem_req=0 for 10 cycles, retired unchanged; start then resumes fetching at the same PC.
REQ-038 Reset mid-MEM with mem_busy=1 -> next cycle IDLE, PC=0, code=0, wr_en never asserted.
